// File: rtl/voice_mix_scheduler.sv
// Shares one amplitude modulator across NUM_VOICES voices: snapshot on sample_tick,
// issue one voice per cycle, accumulate products, emit one saturated mixed sample.
module voice_mix_scheduler #(
  parameter int NUM_VOICES     = 4,
  parameter int DATA_BITS      = 12,
  parameter int AMPLITUDE_BITS = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 sample_tick,
  input  logic [NUM_VOICES*DATA_BITS-1:0]      voice_din,
  input  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] voice_amp,
  input  logic [NUM_VOICES-1:0]                voice_enable,
  output logic [DATA_BITS-1:0]                 mod_din,
  output logic [AMPLITUDE_BITS-1:0]            mod_amp,
  input  logic [DATA_BITS-1:0]                 mod_dout,
  output logic [DATA_BITS-1:0]                 mix_out,
  output logic                                 mix_valid,
  output logic                                 busy,
  output logic                                 overrun,
  output logic [1:0]                           state_dbg
);

  // Handshake: sample_tick is a one-cycle request honoured only in IDLE (no ready
  // back-pressure; a tick seen while busy is dropped and flagged in overrun).
  // mix_valid is a one-cycle pulse; mix_out is stable until the next pulse.

  localparam int ACC_W = DATA_BITS + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (DATA_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2 ** (DATA_BITS - 1)));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t                              state, state_nxt;
  logic [IDX_W-1:0]                    idx, idx_nxt;
  logic [NUM_VOICES*DATA_BITS-1:0]     snap_din;
  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] snap_amp;
  logic [NUM_VOICES-1:0]               snap_en;
  logic signed [ACC_W-1:0]             acc;
  logic                                issue_valid, issue_valid_d;
  logic                                load_snap, acc_clear, emit, overrun_set;
  logic [DATA_BITS-1:0]                mod_din_nxt;
  logic [AMPLITUDE_BITS-1:0]           mod_amp_nxt;
  logic [DATA_BITS-1:0]                sat_val;
  int                                  sel;

  // Voice 0 is loaded into the modulator registers on the accepting edge so that
  // each ISSUE cycle already presents its voice and the last product lands in DRAIN.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    load_snap   = 1'b0;
    acc_clear   = 1'b0;
    emit        = 1'b0;
    issue_valid = 1'b0;
    mod_din_nxt = '0;
    mod_amp_nxt = '0;
    sel         = int'(idx) + 1;
    overrun_set = sample_tick && (state != IDLE);
    case (state)
      IDLE: begin
        if (sample_tick) begin
          state_nxt   = ISSUE;
          load_snap   = 1'b1;
          acc_clear   = 1'b1;
          idx_nxt     = '0;
          mod_din_nxt = voice_din[DATA_BITS-1:0];
          mod_amp_nxt = voice_enable[0] ? voice_amp[AMPLITUDE_BITS-1:0] : '0;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = DRAIN;
        end else begin
          idx_nxt     = idx + 1'b1;
          mod_din_nxt = snap_din[sel*DATA_BITS +: DATA_BITS];
          mod_amp_nxt = snap_en[sel] ? snap_amp[sel*AMPLITUDE_BITS +: AMPLITUDE_BITS] : '0;
        end
      end
      DRAIN: begin
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        emit      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    sat_val = acc[DATA_BITS-1:0];
    if (acc > MAX_V) begin
      sat_val = MAX_V[DATA_BITS-1:0];
    end else if (acc < MIN_V) begin
      sat_val = MIN_V[DATA_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      snap_din      <= '0;
      snap_amp      <= '0;
      snap_en       <= '0;
      acc           <= '0;
      issue_valid_d <= 1'b0;
      mod_din       <= '0;
      mod_amp       <= '0;
      mix_out       <= '0;
      mix_valid     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      issue_valid_d <= issue_valid;
      mod_din       <= mod_din_nxt;
      mod_amp       <= mod_amp_nxt;
      mix_valid     <= emit;
      if (load_snap) begin
        snap_din <= voice_din;
        snap_amp <= voice_amp;
        snap_en  <= voice_enable;
      end
      if (acc_clear) begin
        acc <= '0;
      end else if (issue_valid_d) begin
        acc <= acc + {{(ACC_W-DATA_BITS){mod_dout[DATA_BITS-1]}}, mod_dout};
      end
      if (emit) begin
        mix_out <= sat_val;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
